// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x6 active-low key matrix, debounces one key, encodes it as {is_num, code}.
// Latency: newkey about DEBOUNCE_CYCLES+1 cycles after the key is first seen, plus scan/sync delay.
// Backpressure: none; the consumer must take keycode in the single newkey cycle.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [5:0] cols,
    output logic       newkey,
    output logic [4:0] keycode
);

    localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN    = 2'd0,
        S_PRESS   = 2'd1,
        S_EMIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_rows_meta;
    logic [3:0]     r_rs;
    logic [2:0]     r_col;
    logic [1:0]     r_row;
    logic [3:0]     r_hot;
    logic [SCW-1:0] r_scan_cnt;
    logic [DBW-1:0] r_deb_cnt;
    logic           r_newkey;
    logic [4:0]     r_keycode;

    logic [3:0]     w_low;
    logic           w_one_low;
    logic [1:0]     w_row_idx;
    logic           w_mapped;
    logic [2:0]     w_col_next;

    // Key map: columns 0..3 are digits r*4+c, columns 4 and 5 are operators.
    function automatic logic [4:0] f_map(input logic [1:0] r, input logic [2:0] c);
        logic [4:0] v;
        v = 5'b00000;
        if (c < 3'd4) begin
            v = {1'b1, r, c[1:0]};
        end else if (c == 3'd4) begin
            case (r)
                2'd0:    v = 5'b01010;
                2'd1:    v = 5'b00011;
                2'd2:    v = 5'b00010;
                default: v = 5'b00100;
            endcase
        end else begin
            case (r)
                2'd0:    v = 5'b00001;
                2'd1:    v = 5'b01100;
                2'd2:    v = 5'b01001;
                default: v = 5'b00000;
            endcase
        end
        return v;
    endfunction

    assign w_low      = ~r_rs;
    assign w_one_low  = (w_low != 4'b0000) && ((w_low & (w_low - 4'd1)) == 4'b0000);
    assign w_mapped   = !((r_col == 3'd5) && (w_row_idx == 2'd3));
    assign w_col_next = (r_col == 3'd5) ? 3'd0 : r_col + 3'd1;
    assign cols       = ~(6'd1 << r_col);
    assign newkey     = r_newkey;
    assign keycode    = r_keycode;

    // Convert the one-hot low row pattern to a row index.
    always_comb begin
        w_row_idx = 2'd0;
        case (w_low)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous row lines; idle lines read high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rows_meta <= 4'hF;
            r_rs        <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rs        <= r_rows_meta;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decisions from the synchronized rows and the counters.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SCAN: begin
                if (r_scan_cnt == SCAN_LAST && w_one_low && w_mapped) begin
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (r_rs != r_hot) begin
                    w_state_nxt = S_SCAN;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_state_nxt = S_RELEASE;
            end
            default: begin
                if (r_rs == 4'hF && r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = S_SCAN;
                end
            end
        endcase
    end

    // Column walk, counters, latched key position and the registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col      <= 3'd0;
            r_row      <= 2'd0;
            r_hot      <= 4'hF;
            r_scan_cnt <= '0;
            r_deb_cnt  <= '0;
            r_newkey   <= 1'b0;
            r_keycode  <= 5'b00000;
        end else begin
            r_newkey <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (w_one_low && w_mapped) begin
                            r_hot     <= r_rs;
                            r_row     <= w_row_idx;
                            r_deb_cnt <= '0;
                        end else begin
                            r_col <= w_col_next;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                S_PRESS: begin
                    if (r_rs != r_hot) begin
                        r_deb_cnt  <= '0;
                        r_scan_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        // Load here so keycode is already valid in the newkey cycle.
                        r_deb_cnt <= '0;
                        r_keycode <= f_map(r_row, r_col);
                        r_newkey  <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    r_deb_cnt <= '0;
                end
                default: begin
                    if (r_rs != 4'hF) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb_cnt  <= '0;
                        r_scan_cnt <= '0;
                        r_col      <= w_col_next;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
